pc_fetch_unit: RTL and testbench

//  Fetch stage of the multicycle datapath: holds PC and IR, fetches from instruction memory over a
//  req/ack handshake and drives opcode to the controller. Applies the controller's write strobes
//  (EscCP, EscCondCP, FonteCP) to compute the next PC, then starts the next fetch.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/pc_next_mux.sv | 48 ++++
 rtl/pc_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch stage of the multicycle datapath:
//   next-PC source encodings (FonteCP), fetch FSM state encodings and the
//   field widths used to slice the instruction register.
//   Contents:
//     OPCODE_W       width of the opcode field at the top of IR
//     BR_OFF_W       width of the signed branch offset at ir[7:0]
//     PC_SRC_*       2-bit FonteCP encodings
//     fetch_state_e  fetch FSM states (IDLE, FETCH, VALID, HALT)
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int OPCODE_W = 4;
    localparam int BR_OFF_W = 8;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RSVD   = 2'b11;

    // Explicit encodings keep the state register readable in legacy dumps.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// ----------------------------------------------------------------------------
// pc_next_mux
//   Combinational next-PC selection for the fetch stage. All arithmetic is
//   modulo 2^ADDR_W, so increments and branch offsets wrap naturally.
//   Ports:
//     pc          in   ADDR_W   current PC
//     ir          in   INSTR_W  instruction register (jump target / offset)
//     pc_src      in   2        FonteCP: SEQ, BRANCH, JUMP, RSVD (=SEQ)
//     pc_wr_cond  in   1        EscCondCP: branch is conditional on alu_zero
//     alu_zero    in   1        branch condition from the ALU
//     next_pc     out  ADDR_W   PC to commit on pc_wr
// ----------------------------------------------------------------------------
module pc_next_mux #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] ir,
    input  logic [1:0]         pc_src,
    input  logic               pc_wr_cond,
    input  logic               alu_zero,
    output logic [ADDR_W-1:0]  next_pc
);
    import fetch_pkg::*;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_off;
    logic              br_taken;

    assign pc_inc   = pc + ADDR_W'(1);
    // Size cast of a signed operand sign-extends the 8-bit offset to ADDR_W.
    assign br_off   = ADDR_W'($signed(ir[BR_OFF_W-1:0]));
    // An unconditional branch (EscCondCP low) is always taken; a conditional
    // one falls through to pc+1 so the program still advances.
    assign br_taken = !pc_wr_cond || alu_zero;

    always_comb begin
        // NOTE: assign a default first so no path through the case leaves
        // next_pc unassigned; otherwise synthesis infers a latch.
        next_pc = pc_inc;
        case (pc_src)
            PC_SRC_BRANCH: if (br_taken) next_pc = pc + br_off;
            PC_SRC_JUMP:   next_pc = ir[ADDR_W-1:0];
            default:       next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Fetch stage of the multicycle datapath. Holds PC and IR, fetches from
//   instruction memory over a req/ack handshake, presents the opcode to the
//   controller and commits the next PC when the controller strobes pc_wr.
//   Optional feature macro: IMEM_TIMEOUT_EN -- when defined, a FETCH that
//   waits TIMEOUT_CYC cycles without ack sets sticky fetch_err and parks the
//   unit in HALT until reset. Undefined: FETCH waits indefinitely and
//   fetch_err is tied low.
//   Ports:
//     clk          in   1        clock, rising edge
//     rst          in   1        asynchronous, active-high reset
//     pc_wr        in   1        EscCP: commit next PC (honoured in VALID only)
//     pc_wr_cond   in   1        EscCondCP: branch conditional on alu_zero
//     pc_src       in   2        FonteCP: next-PC source select
//     alu_zero     in   1        branch condition from ALU
//     imem_req     out  1        fetch request, held until ack
//     imem_addr    out  ADDR_W   fetch address (= pc)
//     imem_rdata   in   INSTR_W  instruction data, valid with imem_ack
//     imem_ack     in   1        one-cycle fetch completion
//     pc           out  ADDR_W   current PC
//     ir           out  INSTR_W  instruction register
//     opcode       out  4        top four bits of ir
//     instr_valid  out  1        ir holds the instruction at pc
//     pc_wr_drop   out  1        one-cycle pulse: pc_wr seen outside VALID
//     fetch_err    out  1        sticky fetch timeout flag
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int              ADDR_W      = 8,
    parameter int              INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_wr,
    input  logic               pc_wr_cond,
    input  logic [1:0]         pc_src,
    input  logic               alu_zero,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic               instr_valid,
    output logic               pc_wr_drop,
    output logic               fetch_err
);
    import fetch_pkg::*;

    if (ADDR_W < 8 || INSTR_W < ADDR_W || INSTR_W < OPCODE_W || TIMEOUT_CYC < 1) begin : g_param_check
        $error("pc_fetch_unit: illegal parameter combination");
    end

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] next_pc;
    logic              timeout_hit;

    pc_next_mux #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_pc_next_mux (
        .pc         (pc),
        .ir         (ir),
        .pc_src     (pc_src),
        .pc_wr_cond (pc_wr_cond),
        .alu_zero   (alu_zero),
        .next_pc    (next_pc)
    );

    // Outputs decode directly from the state register, so an asynchronous
    // reset drops imem_req immediately rather than at the next edge.
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_VALID);
    assign imem_addr   = pc;
    assign opcode      = ir[INSTR_W-1 -: OPCODE_W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)         state_d = ST_VALID;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_VALID: if (pc_wr) state_d = ST_FETCH;
`ifdef IMEM_TIMEOUT_EN
            default:  state_d = ST_HALT;
`else
            default:  state_d = ST_IDLE;
`endif
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            pc_wr_drop <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_wr_drop <= pc_wr && (state_q != ST_VALID);
            // Acks outside FETCH (late, or after a reset) never reach ir.
            if (state_q == ST_FETCH && imem_ack) ir <= imem_rdata;
            if (state_q == ST_VALID && pc_wr)    pc <= next_pc;
        end
    end

`ifdef IMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 4) ? 4 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt;

    // The counter holds the number of ack-less FETCH cycles already elapsed;
    // the TIMEOUT_CYC-th such cycle is the one that trips the error.
    assign timeout_hit = (state_q == ST_FETCH) && !imem_ack &&
                         (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            fetch_err <= 1'b0;
        end else begin
            // Held at zero outside FETCH, so it is clear on every FETCH entry.
            if (state_q != ST_FETCH) to_cnt <= '0;
            else if (!imem_ack)      to_cnt <= to_cnt + CNT_W'(1);
            if (timeout_hit)         fetch_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit. A cycle-level behavioural model derives
//   the expected PC/IR/handshake outputs from the fetch rules with plain
//   integer arithmetic; a compare process checks every DUT output against it
//   each cycle, and literal expectations pin the model at key points.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam int ADDR_W      = 8;
    localparam int INSTR_W     = 16;
    localparam int TIMEOUT_CYC = 15;
    localparam int PC_MOD      = 1 << ADDR_W;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_VALID = 2;
    localparam int P_HALT  = 3;

    logic               clk;
    logic               rst;
    logic               pc_wr;
    logic               pc_wr_cond;
    logic [1:0]         pc_src;
    logic               alu_zero;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         opcode;
    logic               instr_valid;
    logic               pc_wr_drop;
    logic               fetch_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_pc    = 0;
    int m_ir    = 0;
    int m_phase = P_IDLE;
    int m_drop  = 0;
    int m_err   = 0;
    int m_wait  = 0;

    pc_fetch_unit #(
        .ADDR_W      (ADDR_W),
        .INSTR_W     (INSTR_W),
        .RESET_PC    (8'h00),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_wr       (pc_wr),
        .pc_wr_cond  (pc_wr_cond),
        .pc_src      (pc_src),
        .alu_zero    (alu_zero),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .pc          (pc),
        .ir          (ir),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc_wr_drop  (pc_wr_drop),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int next_pc_of(input int cur, input int instr, input int src,
                                      input bit cond, input bit zero);
        int off;
        off = instr % 256;
        if (off >= 128) off = off - 256;
        case (src)
            1: begin
                if (!cond || zero) return ((cur + off) % PC_MOD + PC_MOD) % PC_MOD;
                return (cur + 1) % PC_MOD;
            end
            2:       return instr % PC_MOD;
            default: return (cur + 1) % PC_MOD;
        endcase
    endfunction

    // Model: one update per rising edge using the inputs the DUT saw.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pc = 0; m_ir = 0; m_phase = P_IDLE; m_drop = 0; m_err = 0; m_wait = 0;
        end else begin
            m_drop = (pc_wr && m_phase != P_VALID) ? 1 : 0;
            case (m_phase)
                P_IDLE: begin
                    m_phase = P_FETCH;
                    m_wait  = 0;
                end
                P_FETCH: begin
                    if (imem_ack) begin
                        m_ir    = int'(imem_rdata);
                        m_phase = P_VALID;
                    end else begin
                        m_wait++;
`ifdef IMEM_TIMEOUT_EN
                        if (m_wait == TIMEOUT_CYC) begin
                            m_err   = 1;
                            m_phase = P_HALT;
                        end
`endif
                    end
                end
                P_VALID: begin
                    if (pc_wr) begin
                        m_pc    = next_pc_of(m_pc, m_ir, int'(pc_src), pc_wr_cond, alu_zero);
                        m_phase = P_FETCH;
                        m_wait  = 0;
                    end
                end
                default: m_phase = P_HALT;
            endcase
        end
    end

    // Compare: every cycle out of reset, shortly after the active edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            check("cmp_pc",     pc,          m_pc);
            check("cmp_addr",   imem_addr,   m_pc);
            check("cmp_ir",     ir,          m_ir);
            check("cmp_opcode", opcode,      m_ir / 4096);
            check("cmp_req",    imem_req,    m_phase == P_FETCH);
            check("cmp_valid",  instr_valid, m_phase == P_VALID);
            check("cmp_drop",   pc_wr_drop,  m_drop);
            check("cmp_err",    fetch_err,   m_err);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req && n < 50) begin
            tick();
            n++;
        end
        check("wait_req_bound", imem_req, 1'b1);
    endtask

    task automatic fetch(input logic [15:0] data, input int dly);
        wait_req();
        repeat (dly) tick();
        imem_rdata = data;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
    endtask

    task automatic commit(input logic [1:0] src, input logic cond, input logic zero);
        pc_src     = src;
        pc_wr_cond = cond;
        alu_zero   = zero;
        pc_wr      = 1'b1;
        tick();
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        alu_zero   = 1'b0;
        pc_src     = 2'b00;
    endtask

    initial begin
        rst = 1'b0; pc_wr = 1'b0; pc_wr_cond = 1'b0; pc_src = 2'b00; alu_zero = 1'b0;
        imem_rdata = '0; imem_ack = 1'b0;
        #1 rst = 1'b1;
        #11;
        check("rst_pc",    pc,          8'h00);
        check("rst_ir",    ir,          16'h0000);
        check("rst_req",   imem_req,    1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_drop",  pc_wr_drop,  1'b0);
        check("rst_err",   fetch_err,   1'b0);

        // Release reset with a stale ack present: the IDLE cycle ignores it.
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 16'hEEEE;
        rst = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("late_ack_ir",  ir,       16'h0000);
        check("late_ack_req", imem_req, 1'b1);

        fetch(16'hB012, 2);
        check("f0_ir",     ir,          16'hB012);
        check("f0_opcode", opcode,      4'hB);
        check("f0_pc",     pc,          8'h00);
        check("f0_valid",  instr_valid, 1'b1);
        check("f0_model",  m_ir,        32'hB012);

        commit(2'b10, 1'b0, 1'b0);
        check("jump_pc",   pc,       8'h12);
        check("jump_req",  imem_req, 1'b1);

        // pc_wr while fetching is dropped with a single-cycle pulse.
        pc_wr = 1'b1;
        tick();
        pc_wr = 1'b0;
        check("drop_pulse", pc_wr_drop, 1'b1);
        check("drop_pc",    pc,         8'h12);
        tick();
        check("drop_clear", pc_wr_drop, 1'b0);

        fetch(16'h20FF, 0);
        commit(2'b10, 1'b0, 1'b0);
        check("to_ff_pc", pc,        8'hFF);
        check("ff_addr",  imem_addr, 8'hFF);
        fetch(16'h3000, 1);
        commit(2'b00, 1'b0, 1'b0);
        check("wrap_pc",   pc,        8'h00);
        check("wrap_addr", imem_addr, 8'h00);
        check("wrap_model", m_pc,     32'h0);

        fetch(16'h4010, 0);
        commit(2'b10, 1'b0, 1'b0);
        fetch(16'h50FC, 0);
        commit(2'b01, 1'b1, 1'b1);
        check("br_taken_pc", pc, 8'h0C);

        fetch(16'h4010, 0);
        commit(2'b10, 1'b0, 1'b0);
        fetch(16'h50FC, 0);
        commit(2'b01, 1'b1, 1'b0);
        check("br_not_taken_pc", pc, 8'h11);

        fetch(16'h6005, 0);
        commit(2'b01, 1'b0, 1'b0);
        check("br_uncond_pc", pc, 8'h16);

        // In VALID: pc_wr_cond alone and a stray ack must change nothing.
        fetch(16'h7080, 0);
        pc_wr_cond = 1'b1; alu_zero = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1234;
        tick();
        tick();
        pc_wr_cond = 1'b0; alu_zero = 1'b0; imem_ack = 1'b0;
        check("cond_only_pc", pc,          8'h16);
        check("stray_ack_ir", ir,          16'h7080);
        check("cond_valid",   instr_valid, 1'b1);

        commit(2'b01, 1'b0, 1'b0);
        check("br_back_wrap_pc", pc, 8'h96);
        fetch(16'h807F, 0);
        commit(2'b01, 1'b0, 1'b0);
        check("br_fwd_wrap_pc", pc, 8'h15);
        fetch(16'h9000, 0);
        commit(2'b11, 1'b0, 1'b0);
        check("rsvd_pc", pc, 8'h16);

        // Ack and pc_wr in the same FETCH cycle: ack wins, pc_wr dropped.
        wait_req();
        imem_ack = 1'b1; imem_rdata = 16'hA0AA; pc_wr = 1'b1; pc_src = 2'b10;
        tick();
        imem_ack = 1'b0; pc_wr = 1'b0; pc_src = 2'b00;
        check("coinc_ir",    ir,          16'hA0AA);
        check("coinc_pc",    pc,          8'h16);
        check("coinc_drop",  pc_wr_drop,  1'b1);
        check("coinc_valid", instr_valid, 1'b1);
        commit(2'b00, 1'b0, 1'b0);
        check("seq_pc", pc, 8'h17);

        // Reset in the middle of a fetch, with the ack arriving during reset.
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_req",   imem_req,    1'b0);
        check("midrst_pc",    pc,          8'h00);
        check("midrst_ir",    ir,          16'h0000);
        check("midrst_valid", instr_valid, 1'b0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 16'hCCCC;
        tick();
        rst = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("midrst_ack_ir", ir,       16'h0000);
        check("midrst_pc2",    pc,       8'h00);
        check("midrst_req2",   imem_req, 1'b1);

        // Ack withheld well past the timeout threshold.
        repeat (TIMEOUT_CYC + 3) tick();
`ifdef IMEM_TIMEOUT_EN
        check("to_err",   fetch_err,   1'b1);
        check("to_req",   imem_req,    1'b0);
        check("to_valid", instr_valid, 1'b0);
        repeat (3) tick();
        check("to_sticky", fetch_err, 1'b1);
        rst = 1'b1;
        #1;
        check("to_rst_err", fetch_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
`else
        check("noto_err", fetch_err, 1'b0);
        check("noto_req", imem_req,  1'b1);
        check("noto_pc",  pc,        8'h00);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
